// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the instruction fetch unit.
//   - fetch_mode_e  : RUN (issuing) / HALT (parked after a fetch fault)
//   - fetch_entry_t : one fetch queue entry {pc, inst, fault}
//   - INST_BYTES, FETCH_Q_DEPTH, FETCH_CNT_W : sizing constants
package inst_fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_DATA_W  = 32;
  localparam int INST_BYTES    = 4;
  localparam int FETCH_Q_DEPTH = 2;
  localparam int FETCH_CNT_W   = $clog2(FETCH_Q_DEPTH + 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_mode_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
    logic                    fault;
  } fetch_entry_t;

  // Instructions are word aligned; any set low bit is a fetch fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bus bundle around the fetch unit.
//   ROM side     : rom_addr_o (fetch->ROM), rom_data_i, rom_illegal_i (ROM->fetch)
//   execute side : redirect_i, redirect_pc_i
//   decode side  : inst_valid_o, inst_o, inst_pc_o, inst_fault_o (fetch->decode),
//                  inst_ready_i (decode->fetch)
// master = the fetch unit, slave = its environment (ROM, execute, decode).
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic                  rom_illegal_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] inst_pc_o;
  logic                  inst_fault_o;

  modport master (
    output rom_addr_o,
    input  rom_data_i, rom_illegal_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    input  inst_ready_i
  );

  modport slave (
    input  rom_addr_o,
    output rom_data_i, rom_illegal_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    output inst_ready_i
  );
endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// fetch_queue: small synchronous shift FIFO holding fetched instructions.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop all entries (takes priority over push/pop)
//   push, push_entry : write one entry at the tail
//   pop           : retire the head (caller guarantees head_valid)
//   head, head_valid : registered head entry; all-zero when empty
//   count         : number of valid entries
// Slots beyond count are kept at zero so the head reads 0 when empty
// without an output mux.
module fetch_queue
  import inst_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [FETCH_CNT_W-1:0] count
);

  fetch_entry_t [FETCH_Q_DEPTH-1:0] slots, slots_nxt;
  logic [FETCH_CNT_W-1:0]           cnt_nxt, wr_idx;

  // Tail position after this cycle's pop has shifted everything down.
  assign wr_idx = count - FETCH_CNT_W'(pop);

  always_comb begin
    slots_nxt = slots;
    if (pop) begin
      for (int i = 0; i < FETCH_Q_DEPTH - 1; i++) slots_nxt[i] = slots[i+1];
      slots_nxt[FETCH_Q_DEPTH-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < FETCH_Q_DEPTH; i++)
        if (wr_idx == FETCH_CNT_W'(i)) slots_nxt[i] = push_entry;
    end
    cnt_nxt = count + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slots <= '0;
      count <= '0;
    end else begin
      slots <= slots_nxt;
      count <= cnt_nxt;
    end
  end

  assign head       = slots[0];
  assign head_valid = (count != '0);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit in front of a synchronous code ROM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_fetch_if.master
//     rom_addr_o = current PC, sampled by the ROM every edge; rom_data_i /
//     rom_illegal_i answer the address of the previous edge.
//     redirect_i / redirect_pc_i flush everything and restart at a new PC.
//     inst_* present the fetch queue head to decode (pop = valid & ready).
// At most one ROM read is in flight; issue only happens when the queue is
// guaranteed to have room for its response, so decode stalls never drop
// an instruction. A faulting fetch (misaligned PC or ROM illegal) is
// delivered as an entry with inst=0 and parks the unit in HALT until the
// next redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
  parameter int                    DATA_WIDTH = FETCH_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam logic [FETCH_CNT_W:0] Q_DEPTH = (FETCH_CNT_W+1)'(FETCH_Q_DEPTH);

  logic [ADDR_WIDTH-1:0]  pc, inflight_pc;
  logic                   inflight, inflight_mis;
  fetch_mode_e            mode, mode_nxt;
  logic [DATA_WIDTH-1:0]  rom_word;
  logic                   rsp_fault, push, push_fault, pop, issue, credit;
  logic [FETCH_CNT_W-1:0] count;
  logic [FETCH_CNT_W:0]   occ;
  fetch_entry_t           push_entry, head;
  logic                   head_valid;

  assign bus.rom_addr_o = pc;
  assign rom_word       = bus.rom_data_i;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign rsp_fault  = inflight_mis | bus.rom_illegal_i;
  assign push       = inflight & ~bus.redirect_i;
  assign push_fault = push & rsp_fault;
  assign pop        = head_valid & bus.inst_ready_i & ~bus.redirect_i;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.inst  = rsp_fault ? '0 : rom_word;
  assign push_entry.fault = rsp_fault;

  // Credit: entries left after this cycle plus the response now in flight
  // (which lands this cycle) must leave a slot for a new issue's response.
  assign occ    = {1'b0, count} + (FETCH_CNT_W+1)'(inflight) - (FETCH_CNT_W+1)'(pop);
  assign credit = occ < Q_DEPTH;

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) mode <= RUN;
    else     mode <= mode_nxt;
  end

  // Mode FSM: next state
  always_comb begin
    mode_nxt = mode;
    if (bus.redirect_i)  mode_nxt = RUN;
    else if (push_fault) mode_nxt = HALT;
  end

  // Mode FSM: outputs. A fault push squashes the issue of the same cycle.
  always_comb begin
    issue = 1'b0;
    if (mode == RUN && !bus.redirect_i && credit && !push_fault) issue = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_mis <= 1'b0;
    end else if (bus.redirect_i) begin
      pc       <= bus.redirect_pc_i;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc  <= pc;
        inflight_mis <= is_misaligned(pc[1:0]);
        pc           <= pc + ADDR_WIDTH'(INST_BYTES);
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head.inst;
  assign bus.inst_pc_o    = head.pc;
  assign bus.inst_fault_o = head.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// A synchronous ROM model answers every address; a stream model tracks the
// PC decode should see next (restart at redirect/reset target, +4 per
// accepted instruction, stream ends after a faulting entry) and checks
// every accepted instruction. Directed phases check latency, back-pressure,
// redirect, fault and reset behaviour; a random phase mixes ready,
// redirects, misaligned/wrapping targets and an illegal ROM address.
module tb_inst_fetch;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  inst_fetch #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int errors = 0;
  int pops   = 0;

  logic        illegal_en   = 1'b0;
  logic [63:0] illegal_addr = '0;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0000_0013;
      64'h4:   return 32'h0010_0093;
      64'h8:   return 32'h0020_0113;
      default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
    endcase
  endfunction

  function automatic logic exp_fault(input logic [63:0] a);
    return (a[1:0] != 2'b00) || (illegal_en && a == illegal_addr);
  endfunction

  // Synchronous ROM: answers the address sampled on the previous edge.
  always @(posedge clk) begin
    bus.rom_data_i    <= rom_word(bus.rom_addr_o);
    bus.rom_illegal_i <= illegal_en && (bus.rom_addr_o == illegal_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream model / scoreboard
  logic [63:0] exp_pc   = RESET_PC;
  bit          exp_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc   = RESET_PC;
      exp_done = 1'b0;
    end else if (bus.redirect_i) begin
      exp_pc   = bus.redirect_pc_i;
      exp_done = 1'b0;
    end else if (bus.inst_valid_o) begin
      if (exp_done) chk("valid_after_fault", bus.inst_valid_o, 0);
      else if (bus.inst_ready_i) begin
        logic f;
        f = exp_fault(exp_pc);
        chk("pop_pc", bus.inst_pc_o, exp_pc);
        chk("pop_fault", bus.inst_fault_o, f);
        chk("pop_inst", bus.inst_o, f ? 32'h0 : rom_word(exp_pc));
        pops++;
        if (f) exp_done = 1'b1;
        exp_pc = exp_pc + 64'd4;
      end
    end else begin
      chk("empty_zero", bus.inst_pc_o | 64'(bus.inst_o) | 64'(bus.inst_fault_o), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Redirect in cycle t; checks t+1, t+2 empty and target at head in t+3.
  task automatic do_redirect(input logic [63:0] tgt, input logic ill_en, input logic [63:0] ill_addr);
    cyc();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = tgt;
    illegal_en        = ill_en;
    illegal_addr      = ill_addr;
    smp();
    cyc();
    bus.redirect_i = 1'b0;
    smp();
    chk("redir_t1_valid", bus.inst_valid_o, 0);
    cyc(); smp();
    chk("redir_t2_valid", bus.inst_valid_o, 0);
    cyc(); smp();
    chk("redir_t3_valid", bus.inst_valid_o, 1);
    chk("redir_t3_pc", bus.inst_pc_o, tgt);
  endtask

  initial begin
    logic [63:0] hold_addr, hold_pc, tgt;
    int          p0;

    rst               = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.inst_ready_i  = 1'b1;
    repeat (3) cyc();
    smp();
    chk("rst_valid", bus.inst_valid_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_pc", bus.inst_pc_o, 0);
    chk("rst_fault", bus.inst_fault_o, 0);
    chk("rst_addr", bus.rom_addr_o, RESET_PC);

    // Straight line: cycle 0 is the first cycle out of reset.
    cyc(); rst = 1'b0; smp();
    chk("c0_valid", bus.inst_valid_o, 0);
    chk("c0_addr", bus.rom_addr_o, 64'h0);
    cyc(); smp();
    chk("c1_valid", bus.inst_valid_o, 0);
    cyc(); smp();
    chk("c2_valid", bus.inst_valid_o, 1);
    chk("c2_pc", bus.inst_pc_o, 64'h0);
    chk("c2_inst", bus.inst_o, 32'h0000_0013);
    cyc(); smp();
    chk("c3_pc", bus.inst_pc_o, 64'h4);
    chk("c3_inst", bus.inst_o, 32'h0010_0093);
    cyc(); smp();
    chk("c4_pc", bus.inst_pc_o, 64'h8);
    chk("c4_inst", bus.inst_o, 32'h0020_0113);
    chk("c4_fault", bus.inst_fault_o, 0);

    // Back-pressure: ready low for six cycles, PC and head must freeze.
    cyc(); bus.inst_ready_i = 1'b0; smp();
    hold_pc = bus.inst_pc_o;
    cyc(); smp();
    hold_addr = bus.rom_addr_o;
    for (int i = 0; i < 4; i++) begin
      cyc(); smp();
      chk("bp_addr_frozen", bus.rom_addr_o, hold_addr);
      chk("bp_head_held", bus.inst_pc_o, hold_pc);
      chk("bp_valid", bus.inst_valid_o, 1);
    end
    cyc(); bus.inst_ready_i = 1'b1; smp();
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_gap", bus.inst_valid_o, 1);
      cyc(); smp();
    end

    // Redirect with a full queue.
    bus.inst_ready_i = 1'b0;
    repeat (3) cyc();
    smp();
    chk("full_before_redir", bus.inst_valid_o, 1);
    bus.inst_ready_i = 1'b1;
    do_redirect(64'h100, 1'b0, 64'h0);
    repeat (4) begin cyc(); smp(); end

    // Misaligned redirect: one fault entry, then silence until redirect.
    do_redirect(64'h102, 1'b0, 64'h0);
    chk("mis_fault", bus.inst_fault_o, 1);
    chk("mis_inst", bus.inst_o, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); smp();
      chk("mis_halt_valid", bus.inst_valid_o, 0);
    end
    do_redirect(64'h200, 1'b0, 64'h0);
    chk("resume_fault", bus.inst_fault_o, 0);
    chk("resume_inst", bus.inst_o, rom_word(64'h200));

    // ROM illegal on the response for 0x20.
    do_redirect(64'h10, 1'b1, 64'h20);
    repeat (4) begin cyc(); smp(); end
    chk("ill_pc", bus.inst_pc_o, 64'h20);
    chk("ill_fault", bus.inst_fault_o, 1);
    chk("ill_inst", bus.inst_o, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(); smp();
      chk("ill_halt_valid", bus.inst_valid_o, 0);
      chk("ill_halt_addr", bus.rom_addr_o, 64'h24);
    end
    do_redirect(64'h400, 1'b0, 64'h0);
    repeat (3) begin cyc(); smp(); end

    // Reset together with redirect and a pop, mid-stream.
    cyc();
    rst               = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 64'h300;
    smp();
    cyc();
    rst            = 1'b0;
    bus.redirect_i = 1'b0;
    smp();
    chk("rrel_valid", bus.inst_valid_o, 0);
    chk("rrel_inst", bus.inst_o, 0);
    chk("rrel_pc", bus.inst_pc_o, 0);
    chk("rrel_fault", bus.inst_fault_o, 0);
    chk("rrel_addr", bus.rom_addr_o, RESET_PC);
    cyc(); smp();
    chk("rrel_c1_valid", bus.inst_valid_o, 0);
    cyc(); smp();
    chk("rrel_c2_valid", bus.inst_valid_o, 1);
    chk("rrel_c2_pc", bus.inst_pc_o, RESET_PC);

    // Random phase.
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.inst_ready_i = ($urandom_range(0, 3) != 0);
      if (i == 0 || $urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 9))
          0:       tgt = 64'h1000 + 64'($urandom_range(0, 63)) * 4 + 64'($urandom_range(1, 3));
          1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
          default: tgt = 64'h1000 + 64'($urandom_range(0, 63)) * 4;
        endcase
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = tgt;
        illegal_en        = 1'b1;
        illegal_addr      = 64'h1040;
      end else begin
        bus.redirect_i = 1'b0;
      end
    end
    cyc();
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    repeat (10) cyc();
    chk("rand_progress", 64'((pops - p0) > 300), 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that acts as the initiator toward the synchronous code ROM. It keeps the fetch PC and drives ROM read addresses. It absorbs the ROM's fixed one-cycle read latency and buffers returned words in a 2-entry queue so that decode back-pressure never loses an instruction. It sits between the code ROM and the decode stage, and accepts PC redirects from execute for branches, jumps and traps.

## Interface
- ADDR_WIDTH, 64, fetch address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr_o  out  ADDR_WIDTH  ROM read address; ROM samples it every edge
- rom_data_i  in  DATA_WIDTH  ROM word for the address sampled on the previous edge
- rom_illegal_i  in  1  ROM access fault for that same address
- redirect_i  in  1  load redirect_pc_i and flush
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- inst_valid_o  out  1  queue head valid
- inst_ready_i  in  1  decode accepts head; pop = inst_valid_o & inst_ready_i
- inst_o  out  DATA_WIDTH  instruction; 0 when faulting
- inst_pc_o  out  ADDR_WIDTH  PC of inst_o
- inst_fault_o  out  1  head is a fetch fault (misaligned PC or ROM illegal)

## Operation
- State: pc, inflight (1 bit), inflight_pc, inflight_mis, 2-entry queue of {pc, inst, fault}, mode RUN/HALT.
- rom_addr_o = pc, combinational from the register, always driven; responses are used only when inflight = 1.
- Issue condition: mode = RUN, no redirect_i, and (count + inflight − pop) < 2.
- On issue:
  - inflight ← 1, inflight_pc ← pc, inflight_mis ← (pc[1:0] ≠ 0).
  - pc ← pc + 4, wrapping modulo 2^ADDR_WIDTH.
- Without issue, inflight ← 0.
- Response cycle (inflight = 1): push {inflight_pc, rom_data_i, inflight_mis | rom_illegal_i}. If fault is set, the pushed inst is 0.
- Fault push:
  - mode ← HALT.
  - A fetch issued in the same cycle is squashed (inflight ← 0).
  - pc is not advanced further.
  - The fault entry is still delivered.
- HALT issues nothing until redirect_i.
- Redirect (highest priority after rst):
  - Queue is cleared.
  - inflight ← 0; any response arriving next cycle is discarded.
  - pc ← redirect_pc_i, mode ← RUN.
  - No issue and no pop take effect in the redirect cycle. inst_ready_i is ignored in that cycle and the head is dropped.
- Simultaneous push and pop on a full queue is legal; the credit rule guarantees no overflow.
- The queue never underflows: pop requires valid.

## Timing
- Reset values:
  - pc = RESET_PC, queue empty, inflight = 0, mode = RUN.
  - inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, inst_fault_o = 0.
  - rom_addr_o = RESET_PC.
- Reset mid-operation discards everything in one edge and overrides redirect_i.
- Queue outputs are registered; empty-queue outputs are 0.
- Latency: issue in cycle t → ROM data in t+1 → pushed at end of t+1 → inst_valid_o in t+2.
- First cycle after reset release = cycle 0; first inst_valid_o in cycle 2.
- Redirect in cycle t → first issue t+1 → inst_valid_o in t+3.
- Throughput: 1 instruction/cycle sustained while inst_ready_i = 1.

## Structure
- Shared package:
  - fetch mode enum {RUN, HALT}.
  - INST_BYTES = 4.
  - FETCH_Q_DEPTH = 2.
  - Queue entry struct {pc, inst, fault}.
- Sub-module fetch_queue: 2-entry synchronous FIFO with push, pop, flush and count, on clk/rst. It holds the entries; issue credit and mode logic stay in inst_fetch.

## Test plan
- Straight line: ROM words 0x00000013, 0x00100093, 0x00200113 at 0, 4, 8; ready held high → valid from cycle 2 with pc 0, 4, 8 on consecutive cycles, correct data, fault = 0.
- Back-pressure: ready low cycles 3–8 → queue holds exactly 2 entries, rom_addr_o stops advancing; after ready rises, PCs continue in order with no gap or duplicate.
- Redirect with full queue to 0x100 in cycle t → inst_valid_o low in t+1 and t+2; first entry pc 0x100 in t+3; no pre-redirect PC ever appears after it.
- Misaligned redirect to 0x102 → single entry pc 0x102, inst 0, fault 1; then inst_valid_o stays 0 for 10 cycles; redirect to 0x200 resumes normally.
- rom_illegal_i forced high on the response for pc 0x20 → entry pc 0x20, fault 1, inst 0; no entry for 0x24; HALT until redirect.
- rst asserted together with redirect_i and a pop mid-stream → after release, all outputs 0 and first fetch pc = RESET_PC.
